// File: rtl/cim_pkg.sv
// Shared constants and encodings for the CIM readout datapath
// (column readout -> psum_accum -> ReLU).
package cim_pkg;

   localparam int LANES         = 64;
   localparam int COL_WIDTH     = 10;
   localparam int ACT_BITS      = 4;
   localparam int OUT_PRECISION = 18;

   localparam int PLANE_W = (ACT_BITS > 2) ? $clog2(ACT_BITS) : 1;

   // Internal add width: wide enough that acc + largest shifted term never wraps
   // before the clamp looks at it.
   localparam int TERM_W = COL_WIDTH + ACT_BITS;
   localparam int SUM_W  = ((OUT_PRECISION > TERM_W) ? OUT_PRECISION : TERM_W) + 1;

   // Saturation bounds, also used by ReLU.
   localparam logic signed [OUT_PRECISION-1:0] SAT_MAX = {1'b0, {(OUT_PRECISION-1){1'b1}}};
   localparam logic signed [OUT_PRECISION-1:0] SAT_MIN = {1'b1, {(OUT_PRECISION-1){1'b0}}};

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } psum_state_t;

endpackage

// File: rtl/psum_lane.sv
// One accumulator lane: sign-extend the column sum, shift it to its bit-plane
// weight, saturating-add it onto the running partial sum.
module psum_lane
   import cim_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic                     accum,
   input  logic [PLANE_W-1:0]       shamt,
   input  logic [COL_WIDTH-1:0]     col,
   output logic [OUT_PRECISION-1:0] sum_sat,
   output logic                     sat
);

   localparam logic signed [SUM_W-1:0] HI = SUM_W'(SAT_MAX);
   localparam logic signed [SUM_W-1:0] LO = SUM_W'(SAT_MIN);

   logic signed [OUT_PRECISION-1:0] acc;
   logic signed [SUM_W-1:0]         term;
   logic signed [SUM_W-1:0]         base;
   logic signed [SUM_W-1:0]         sum;

   // A load starts from zero so the first plane goes through the same clamp path.
   always_comb begin
      term    = SUM_W'($signed(col)) <<< shamt;
      base    = load ? '0 : SUM_W'(acc);
      sum     = base + term;
      sum_sat = sum[OUT_PRECISION-1:0];
      sat     = 1'b0;
      if (sum > HI) begin
         sum_sat = SAT_MAX;
         sat     = 1'b1;
      end else if (sum < LO) begin
         sum_sat = SAT_MIN;
         sat     = 1'b1;
      end
   end

   // Running partial sum for this lane.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (load || accum) begin
         acc <= sum_sat;
      end
   end

endmodule

// File: rtl/psum_accum.sv
// Bit-serial partial-sum accumulator feeding ReLU. Shift-adds per-plane column
// sums across activation planes and row tiles, emitting one registered vector
// of saturated partial sums per output pixel.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | waiting for a col_first beat; other beats are dropped
//  ST_ACCUM | accumulating planes/tiles until the wrap beat of the last tile
module psum_accum
   import cim_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           col_valid,
   input  logic                           col_first,
   input  logic                           tile_last,
   input  logic [COL_WIDTH*LANES-1:0]     col_sum,
   output logic [OUT_PRECISION*LANES-1:0] psum_out,
   output logic                           psum_valid,
   output logic                           sat_flag,
   output logic                           busy
);

   psum_state_t state, state_nxt;

   logic [PLANE_W-1:0]             plane_cnt;
   logic [PLANE_W-1:0]             shamt;
   logic                           sat_acc;
   logic                           load;
   logic                           accum;
   logic                           emit;
   logic                           wrap;
   logic [LANES-1:0]               lane_sat;
   logic [OUT_PRECISION*LANES-1:0] lane_sum;

   assign wrap = (plane_cnt == PLANE_W'(ACT_BITS-1));
   assign busy = (state == ST_ACCUM);

   // Next-state and beat classification.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      accum     = 1'b0;
      emit      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (col_valid && col_first) begin
               load      = 1'b1;
               state_nxt = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (col_valid) begin
               if (col_first) begin
                  load = 1'b1;
               end else begin
                  accum = 1'b1;
                  if (wrap && tile_last) begin
                     emit      = 1'b1;
                     state_nxt = ST_IDLE;
                  end
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      shamt = load ? '0 : plane_cnt;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Plane counter and sticky saturation for the accumulation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         plane_cnt <= '0;
         sat_acc   <= 1'b0;
      end else if (load) begin
         plane_cnt <= PLANE_W'(1);
         sat_acc   <= 1'b0;
      end else if (accum) begin
         plane_cnt <= wrap ? '0 : plane_cnt + PLANE_W'(1);
         sat_acc   <= sat_acc | (|lane_sat);
      end
   end

   // Output buffer: holds the last result while the next pixel accumulates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psum_out   <= '0;
         psum_valid <= 1'b0;
         sat_flag   <= 1'b0;
      end else begin
         psum_valid <= emit;
         if (emit) begin
            psum_out <= lane_sum;
            sat_flag <= sat_acc | (|lane_sat);
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      psum_lane u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (load),
         .accum   (accum),
         .shamt   (shamt),
         .col     (col_sum[i*COL_WIDTH +: COL_WIDTH]),
         .sum_sat (lane_sum[i*OUT_PRECISION +: OUT_PRECISION]),
         .sat     (lane_sat[i])
      );
   end

endmodule
